// File: rtl/rx_frame_ctrl_if.sv
// Receive-side bus for rx_frame_ctrl: serial line, bit-timer control and the
// holding-buffer handshake with its status flags.
interface rx_frame_ctrl_if #(
   parameter int DATA_BITS = 8
) ();

   logic                 serial_in;
   logic                 shift_strobe;
   logic                 timer_clear;
   logic                 timer_enable;
   logic                 data_read;
   logic [DATA_BITS-1:0] rx_data;
   logic                 data_ready;
   logic                 framing_error;
   logic                 overrun_error;

   // Frame controller side
   modport slave (
      input  serial_in,
      input  shift_strobe,
      input  data_read,
      output timer_clear,
      output timer_enable,
      output rx_data,
      output data_ready,
      output framing_error,
      output overrun_error
   );

   // Line driver / bit timer / consumer side
   modport master (
      output serial_in,
      output shift_strobe,
      output data_read,
      input  timer_clear,
      input  timer_enable,
      input  rx_data,
      input  data_ready,
      input  framing_error,
      input  overrun_error
   );

endinterface

// File: rtl/rx_frame_ctrl.sv
// UART-style receive frame controller. Detects the start edge, steers an
// external bit-period timer, samples on the timer's mid-bit strobe,
// deserialises LSB-first, checks the stop bit and holds the word for a
// ready/read handshake with framing and overrun flags.
module rx_frame_ctrl #(
   parameter int DATA_BITS = 8
) (
   input  logic           clk,
   input  logic           n_rst,
   rx_frame_ctrl_if.slave bus
);

   localparam int                CNT_W    = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_START_CHK,
      S_DATA,
      S_STOP
   } state_t;

   state_t               r_state;
   logic                 r_prev_serial;
   logic [DATA_BITS-1:0] r_shreg;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic                 r_timer_clear;
   logic                 r_timer_enable;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_data_ready;
   logic                 r_framing_error;
   logic                 r_overrun_error;

   logic                 w_start_edge;
   logic                 w_stop_sample;
   logic                 w_load;
   logic                 w_frame_err;
   logic                 w_read;

   // Start edges only count while idle; mid-frame falls are plain data.
   assign w_start_edge  = (r_state == S_IDLE) && r_prev_serial && !bus.serial_in;
   assign w_stop_sample = (r_state == S_STOP) && bus.shift_strobe;
   assign w_load        = w_stop_sample && bus.serial_in;
   assign w_frame_err   = w_stop_sample && !bus.serial_in;
   assign w_read        = bus.data_read && r_data_ready;

   // Previous line level, for falling-edge detection.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_prev_serial <= 1'b1;
      else        r_prev_serial <= bus.serial_in;
   end

   // Frame FSM with the shift register and bit counter; timer controls are
   // registered from the next state so they track the state exactly.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state        <= S_IDLE;
         r_shreg        <= '0;
         r_bit_cnt      <= '0;
         r_timer_clear  <= 1'b0;
         r_timer_enable <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_edge) begin
                  r_state        <= S_CLR;
                  r_timer_clear  <= 1'b1;
                  r_timer_enable <= 1'b0;
               end
            end
            S_CLR: begin
               r_bit_cnt      <= '0;
               r_state        <= S_START_CHK;
               r_timer_clear  <= 1'b0;
               r_timer_enable <= 1'b1;
            end
            S_START_CHK: begin
               if (bus.shift_strobe) begin
                  if (!bus.serial_in) begin
                     r_state <= S_DATA;
                  end else begin
                     // Line is back high at mid-bit: glitch, not a start bit.
                     r_state        <= S_IDLE;
                     r_timer_enable <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               if (bus.shift_strobe) begin
                  r_shreg   <= {bus.serial_in, r_shreg[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (r_bit_cnt == LAST_BIT) r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (bus.shift_strobe) begin
                  r_state        <= S_IDLE;
                  r_timer_enable <= 1'b0;
               end
            end
            default: begin
               r_state        <= S_IDLE;
               r_timer_clear  <= 1'b0;
               r_timer_enable <= 1'b0;
            end
         endcase
      end
   end

   // Holding buffer and status flags. A load in the same cycle as a read
   // wins: the new word stays ready and the read absorbs the old one, so no
   // overrun is flagged.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_rx_data       <= '0;
         r_data_ready    <= 1'b0;
         r_overrun_error <= 1'b0;
      end else if (w_load) begin
         r_rx_data       <= r_shreg;
         r_data_ready    <= 1'b1;
         r_overrun_error <= r_data_ready && !bus.data_read;
      end else if (w_read) begin
         r_data_ready    <= 1'b0;
         r_overrun_error <= 1'b0;
      end
   end

   // Framing error lives until the next start edge (false starts included).
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)           r_framing_error <= 1'b0;
      else if (w_start_edge) r_framing_error <= 1'b0;
      else if (w_frame_err)  r_framing_error <= 1'b1;
   end

   assign bus.timer_clear   = r_timer_clear;
   assign bus.timer_enable  = r_timer_enable;
   assign bus.rx_data       = r_rx_data;
   assign bus.data_ready    = r_data_ready;
   assign bus.framing_error = r_framing_error;
   assign bus.overrun_error = r_overrun_error;

endmodule
